conv_array_ctrl: RTL

- Sequencer for one conv_kernel array row-pass: walks the KxK weight taps, drives weight-ROM and line-buffer addresses, and pulses the array's clear input.
- Flags each completed output row to the pooling/writeback stage.
- Sits between the top-level layer controller (start/done) and the pixel line buffer, weight ROM and kernel array.
- Pixel-source stalls are absorbed by forcing a zero-weight tap, because the kernel array has no enable input.

---
 rtl/conv_array_ctrl_pkg.sv | 32 +++
 rtl/conv_tap_counter.sv | 51 +++++
 rtl/conv_array_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/conv_array_ctrl_pkg.sv
// ============================================================================
// Module   : conv_array_ctrl_pkg
// Brief    : Shared types and helpers for the conv_kernel row-pass sequencer:
//            FSM state encoding and a minimum-1 address-width helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_array_ctrl_pkg;

  // Sequencer states, explicit 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ACCUM = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Width of the optional stall counter
  localparam int unsigned c_STALL_CNT_W = 16;

  // Address width for a range of n values, never narrower than one bit
  function automatic int unsigned width_of(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w == 0) ? 1 : w;
  endfunction

endpackage : conv_array_ctrl_pkg

`default_nettype wire

// File: rtl/conv_tap_counter.sv
// ============================================================================
// Module   : conv_tap_counter
// Brief    : Nested kx/ky counter over a KxK kernel window. kx is the fast
//            index; ky advances when kx wraps. Flags the final tap (K-1,K-1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_tap_counter #(
  parameter int KERNEL_SIZE = 3,
  parameter int CNT_W       = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_adv,
  output logic [CNT_W-1:0] o_kx,
  output logic [CNT_W-1:0] o_ky,
  output logic             o_last
);

  localparam logic [CNT_W-1:0] c_KMAX = CNT_W'(KERNEL_SIZE - 1);

  logic [CNT_W-1:0] r_kx;
  logic [CNT_W-1:0] r_ky;

  // Tap position: clear to origin, otherwise step raster-order on advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kx <= '0;
      r_ky <= '0;
    end else if (i_clear) begin
      r_kx <= '0;
      r_ky <= '0;
    end else if (i_adv) begin
      if (r_kx == c_KMAX) begin
        r_kx <= '0;
        r_ky <= (r_ky == c_KMAX) ? '0 : r_ky + 1'b1;
      end else begin
        r_kx <= r_kx + 1'b1;
      end
    end
  end

  assign o_kx   = r_kx;
  assign o_ky   = r_ky;
  assign o_last = (r_kx == c_KMAX) && (r_ky == c_KMAX);

endmodule : conv_tap_counter

`default_nettype wire

// File: rtl/conv_array_ctrl.sv
// ============================================================================
// Module   : conv_array_ctrl
// Brief    : Row-pass sequencer for the conv_kernel array. Walks the KxK
//            weight taps for each output row, drives weight-ROM and line-
//            buffer addresses, pulses the array clear and flags each finished
//            output row. Pixel stalls become zero-weight taps (o_tap_en=0)
//            since the array itself cannot be paused.
//            Optional build macro CONV_ARRAY_CTRL_STALL_CNT_EN adds a
//            saturating 16-bit count of stalled accumulate cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_array_ctrl
  import conv_array_ctrl_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_ROWS    = 8,
  parameter int MAC_LAT     = 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          i_start,
  input  logic                                          i_pix_valid,
  output logic                                          o_busy,
  output logic                                          o_done,
  output logic                                          o_clear,
  output logic                                          o_tap_en,
  output logic [width_of(KERNEL_SIZE*KERNEL_SIZE)-1:0]  o_weight_addr,
  output logic [width_of(IMG_ROWS)-1:0]                 o_pix_row,
  output logic [width_of(KERNEL_SIZE)-1:0]              o_pix_col,
  output logic                                          o_out_valid,
  output logic [width_of(IMG_ROWS)-1:0]                 o_out_row
`ifdef CONV_ARRAY_CTRL_STALL_CNT_EN
  ,
  output logic [c_STALL_CNT_W-1:0]                      o_stall_cnt
`endif
);

  localparam int unsigned c_WA_W    = width_of(KERNEL_SIZE * KERNEL_SIZE);
  localparam int unsigned c_ROW_W   = width_of(IMG_ROWS);
  localparam int unsigned c_K_W     = width_of(KERNEL_SIZE);
  localparam int unsigned c_DRAIN_W = width_of(MAC_LAT + 1);

  localparam logic [c_ROW_W-1:0]   c_LAST_ROW   = c_ROW_W'(IMG_ROWS - KERNEL_SIZE);
  localparam logic [c_DRAIN_W-1:0] c_DRAIN_LAST = c_DRAIN_W'(MAC_LAT - 1);
  localparam logic [c_WA_W-1:0]    c_K_MUL      = c_WA_W'(KERNEL_SIZE);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_ROW_W-1:0]    r_row;
  logic [c_DRAIN_W-1:0]  r_drain_cnt;
  logic                  r_out_valid;
  logic [c_ROW_W-1:0]    r_out_row;

  logic [c_K_W-1:0]      w_kx;
  logic [c_K_W-1:0]      w_ky;
  logic                  w_last_tap;
  logic                  w_tap_clear;
  logic                  w_tap_adv;
  logic                  w_in_accum;
  logic                  w_start_acc;
  logic                  w_drain_end;
  logic                  w_row_last;
  logic [c_WA_W-1:0]     w_weight_addr;
  logic [c_ROW_W-1:0]    w_pix_row;

  assign w_start_acc = (r_state == ST_IDLE) && i_start;
  assign w_drain_end = (r_state == ST_DRAIN) && (r_drain_cnt == c_DRAIN_LAST);
  assign w_row_last  = (r_row == c_LAST_ROW);
  assign w_tap_clear = (r_state == ST_CLEAR);

  conv_tap_counter #(
    .KERNEL_SIZE (KERNEL_SIZE),
    .CNT_W       (c_K_W)
  ) u_tap_counter (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_tap_clear),
    .i_adv   (w_tap_adv),
    .o_kx    (w_kx),
    .o_ky    (w_ky),
    .o_last  (w_last_tap)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and Moore/Mealy control outputs
  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    o_clear     = 1'b0;
    o_tap_en    = 1'b0;
    w_tap_adv   = 1'b0;
    w_in_accum  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        o_clear     = 1'b1;
        w_state_nxt = ST_ACCUM;
      end
      ST_ACCUM: begin
        // A stalled pixel source turns this cycle into a zero-weight tap
        w_in_accum = 1'b1;
        o_tap_en   = i_pix_valid;
        w_tap_adv  = i_pix_valid;
        if (i_pix_valid && w_last_tap) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_drain_end) begin
          w_state_nxt = w_row_last ? ST_DONE : ST_CLEAR;
        end
      end
      ST_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Address generation; addresses are only meaningful while accumulating
  assign w_weight_addr = (c_WA_W'(w_ky) * c_K_MUL) + c_WA_W'(w_kx);
  assign w_pix_row     = r_row + c_ROW_W'(w_ky);

  always_comb begin
    o_weight_addr = '0;
    o_pix_row     = '0;
    o_pix_col     = '0;
    if (w_in_accum) begin
      o_weight_addr = w_weight_addr;
      o_pix_row     = w_pix_row;
      o_pix_col     = w_kx;
    end
  end

  // Output-row index: restart on accepted start, step after each drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row <= '0;
    end else if (w_start_acc) begin
      r_row <= '0;
    end else if (w_drain_end && !w_row_last) begin
      r_row <= r_row + 1'b1;
    end
  end

  // Drain timer: counts MAC_LAT cycles so the array output has settled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drain_cnt <= '0;
    end else if (r_state == ST_DRAIN) begin
      r_drain_cnt <= r_drain_cnt + 1'b1;
    end else begin
      r_drain_cnt <= '0;
    end
  end

  // Finished-row flag lands in the cycle after drain (next CLEAR or DONE)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_row   <= '0;
    end else begin
      r_out_valid <= w_drain_end;
      r_out_row   <= w_drain_end ? r_row : '0;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_row   = r_out_row;

`ifdef CONV_ARRAY_CTRL_STALL_CNT_EN
  logic [c_STALL_CNT_W-1:0] r_stall_cnt;

  // Saturating count of accumulate cycles lost to pixel stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_start_acc) begin
      r_stall_cnt <= '0;
    end else if (w_in_accum && !i_pix_valid && (r_stall_cnt != {c_STALL_CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule : conv_array_ctrl

`default_nettype wire
